// File: rtl/ysyx_22040931_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_mem_arbiter_pkg
// Shared types and defaults for the IFU/LSU memory arbiter.
//   arb_state_e : IDLE / REQ / RESP transaction states
//   arb_owner_e : which requester owns the current transaction
//   ARB_ADDR_W / ARB_DATA_W : default address and data widths
// ----------------------------------------------------------------------------
package ysyx_22040931_mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_22040931_mem_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_rr_pick2
// Combinational two-way round-robin picker.
//   req_i[1:0] : request vector, bit 0 = IFU, bit 1 = LSU
//   last_i     : requester granted most recently
//   grant_o    : one-hot grant, or zero when nobody requests
// On a tie the requester that did not win last time is chosen.
// ----------------------------------------------------------------------------
module ysyx_22040931_rr_pick2
    import ysyx_22040931_mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_owner_e last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_i == OWN_LSU) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22040931_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_mem_arbiter
// Shares the single memory port between the IFU (reads) and LSU (reads and
// writes). One transaction in flight at a time; round-robin on ties.
//   clk, rst                   : core clock, asynchronous active-high reset
//   ifu_req_* / ifu_resp_*     : IFU read request / response
//   lsu_req_* / lsu_resp_*     : LSU read/write request / response
//   mem_req_* / mem_resp_*     : towards the memory / DPI bridge
// Flow: IDLE (arbitrate + latch) -> REQ (hold request until accepted)
//       -> RESP (route response to owner) -> IDLE.
// ----------------------------------------------------------------------------
module ysyx_22040931_mem_arbiter
    import ysyx_22040931_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e          state_q;
    arb_owner_e          owner_q;
    arb_owner_e          last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;

    logic [1:0]          grant;
    arb_owner_e          winner;
    logic                in_idle;
    logic                resp_hit;

    ysyx_22040931_rr_pick2 u_pick (
        .req_i   ({lsu_req_valid, ifu_req_valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign winner  = grant[1] ? OWN_LSU : OWN_IFU;
    // Ready is gated by rst so that every output reads 0 while reset is held,
    // even if a requester keeps its valid asserted.
    assign in_idle = (state_q == ARB_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant != 2'b00) begin
                        owner_q <= winner;
                        last_q  <= winner;
                        state_q <= ARB_REQ;
                        if (winner == OWN_LSU) begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end else begin
                            // Fetches are always reads.
                            addr_q  <= ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_resp_valid) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign ifu_req_ready = in_idle && grant[0];
    assign lsu_req_ready = in_idle && grant[1];

    assign mem_req_valid = (state_q == ARB_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Responses outside RESP are stray and dropped.
    assign resp_hit       = (state_q == ARB_RESP) && mem_resp_valid;
    assign ifu_resp_valid = resp_hit && (owner_q == OWN_IFU);
    assign lsu_resp_valid = resp_hit && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040931_mem_arbiter
// Directed scenarios plus a randomised run against a small reference model.
// Inputs change 1 ns after the rising edge, outputs are sampled 4 ns after it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_22040931_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040931_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        ifu_req_valid = 1; lsu_req_valid = 1;
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got addr %h wen %b wdata %h wmask %h expected all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        step();
        clear_inputs();
        rst = 0;
        $display("reset: outputs checked");
    endtask

    task automatic test_ifu_single();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #3;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++; $display("FAIL ifu_ready: got %b expected 10", {ifu_req_ready, lsu_req_ready});
        end
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        #3;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready} !== {1'b1, 32'h8000_0000, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL ifu_memreq: got valid %b addr %h wen %b wmask %h rdy %b expected 1 80000000 0 00 0",
                     mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready);
        end
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h1234;
        #3;
        checks++;
        if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata} !== {1'b1, 64'h1234, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL ifu_resp: got ifu %b %h lsu %b %h expected 1 1234 0 0",
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata);
        end
        step();
        mem_resp_valid = 0;
        #3;
        checks++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
            errors++; $display("FAIL ifu_back_idle: got %b expected 00", {mem_req_valid, ifu_resp_valid});
        end
        $display("ifu_single: addr 80000000 rdata 1234");
    endtask

    task automatic test_round_robin();
        logic exp_lsu;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2) == 1;
            ifu_req_valid = 1; ifu_addr = 32'h8000_0100 + i;
            lsu_req_valid = 1; lsu_addr = 32'h8000_0200 + i; lsu_wen = 0;
            #3;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {!exp_lsu, exp_lsu});
            end
            step();
            ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
            #3;
            checks++;
            if (mem_addr !== (exp_lsu ? 32'h8000_0200 + i : 32'h8000_0100 + i)) begin
                errors++; $display("FAIL rr_addr%0d: got %h", i, mem_addr);
            end
            step();
            mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h100 + i;
            #3;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid} !== {!exp_lsu, exp_lsu}) begin
                errors++;
                $display("FAIL rr_resp%0d: got %b expected %b", i, {ifu_resp_valid, lsu_resp_valid}, {!exp_lsu, exp_lsu});
            end
            step();
            mem_resp_valid = 0;
            $display("round_robin: tie %0d winner %s", i, exp_lsu ? "LSU" : "IFU");
        end
    endtask

    task automatic test_lsu_write_stall();
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        #3;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++; $display("FAIL lsu_ready: got %b expected 01", {ifu_req_ready, lsu_req_ready});
        end
        step();
        lsu_req_valid = 0; lsu_wdata = 0; lsu_addr = 0; lsu_wmask = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready = (c == 3);
            #3;
            checks++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready}
                !== {1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0}) begin
                errors++;
                $display("FAIL lsu_hold%0d: got v %b a %h w %b d %h m %h rdy %b expected 1 80001000 1 deadbeef 0f 0",
                         c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
            end
            step();
        end
        mem_req_ready = 0; ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'h0;
        #3;
        checks++;
        if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin
            errors++; $display("FAIL lsu_ack: got %b expected 10", {lsu_resp_valid, ifu_resp_valid});
        end
        step();
        mem_resp_valid = 0;
        $display("lsu_write: addr 80001000 wdata deadbeef wmask 0f stalled 3 cycles");
    endtask

    task automatic test_stray_resp();
        int pulses = 0;
        mem_resp_valid = 1; mem_rdata = 64'h5555;
        #3;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            errors++; $display("FAIL stray_idle: got %b expected 00", {ifu_resp_valid, lsu_resp_valid});
        end
        step();
        mem_resp_valid = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
        step();
        ifu_req_valid = 0;
        for (int c = 0; c < 2; c++) begin
            mem_req_ready = (c == 1); mem_resp_valid = 1;
            #3;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
                errors++; $display("FAIL stray_req%0d: got %b expected 00", c, {ifu_resp_valid, lsu_resp_valid});
            end
            step();
        end
        mem_req_ready = 0;
        for (int c = 0; c < 3; c++) begin
            mem_resp_valid = 1; mem_rdata = 64'hABCD;
            #3;
            if (ifu_resp_valid) pulses++;
            if (c == 0) begin
                checks++;
                if (ifu_rdata !== 64'hABCD) begin
                    errors++; $display("FAIL stray_rdata: got %h expected abcd", ifu_rdata);
                end
            end
            step();
        end
        mem_resp_valid = 0;
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL stray_pulses: got %0d expected 1", pulses);
        end
        $display("stray_resp: pulses to owner %0d", pulses);
    endtask

    task automatic test_async_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        #2;
        rst = 1;
        mem_resp_valid = 1; mem_rdata = 64'h7777;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_addr, ifu_rdata} !== '0) begin
            errors++;
            $display("FAIL async_rst: got reqv %b ifu %b lsu %b addr %h rdata %h expected all 0",
                     mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_addr, ifu_rdata);
        end
        rst = 0;
        mem_resp_valid = 0;
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_2000;
        #3;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++; $display("FAIL async_regrant: got %b expected 1", ifu_req_ready);
        end
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        #3;
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_2000}) begin
            errors++; $display("FAIL async_memreq: got %b %h expected 1 80002000", mem_req_valid, mem_addr);
        end
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h42;
        #3;
        checks++;
        if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 64'h42}) begin
            errors++; $display("FAIL async_resp: got %b %h expected 1 42", ifu_resp_valid, ifu_rdata);
        end
        step();
        mem_resp_valid = 0;
        $display("async_reset: abandoned in RESP, next fetch 80002000 ok");
    endtask

    task automatic test_stress();
        int          m_state = 0;
        logic        m_last  = 1'b1;
        logic        m_owner = 1'b0;
        logic [31:0] m_addr  = '0;
        logic [1:0]  g;
        logic [4:0]  exp_v, got_v;
        int          n_resp  = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ifu_req_valid  = 1'($urandom_range(0, 1));
            lsu_req_valid  = 1'($urandom_range(0, 1));
            ifu_addr       = $urandom;
            lsu_addr       = $urandom;
            lsu_wen        = 1'($urandom_range(0, 1));
            lsu_wdata      = {$urandom, $urandom};
            lsu_wmask      = 8'($urandom);
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_rdata      = {$urandom, $urandom};
            g = 2'b00;
            if (m_state == 0) begin
                if (ifu_req_valid && lsu_req_valid) g = m_last ? 2'b01 : 2'b10;
                else g = {lsu_req_valid, ifu_req_valid};
            end
            exp_v = {g[0], g[1], m_state == 1,
                     m_state == 2 && mem_resp_valid && !m_owner,
                     m_state == 2 && mem_resp_valid && m_owner};
            #3;
            got_v = {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid};
            checks++;
            if (got_v !== exp_v || (m_state == 1 && mem_addr !== m_addr)
                || ifu_rdata !== (exp_v[1] ? mem_rdata : 64'h0)
                || lsu_rdata !== (exp_v[0] ? mem_rdata : 64'h0)) begin
                errors++;
                $display("FAIL stress_cyc%0d: got ctl %b addr %h expected ctl %b addr %h",
                         cyc, got_v, mem_addr, exp_v, m_addr);
            end
            case (m_state)
                0: if (g != 2'b00) begin
                       m_state = 1; m_owner = g[1]; m_last = g[1];
                       m_addr  = g[1] ? lsu_addr : ifu_addr;
                   end
                1: if (mem_req_ready) m_state = 2;
                default: if (mem_resp_valid) begin m_state = 0; n_resp++; end
            endcase
            step();
        end
        clear_inputs();
        $display("stress: 3000 cycles, %0d responses", n_resp);
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_ifu_single();
        test_round_robin();
        test_lsu_write_stall();
        test_stray_resp();
        test_async_reset();
        test_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
